// File: rtl/sll32_seq.sv
// Multi-cycle logical left shifter: res = B << A[4:0], STEP bits per clock.
// A start/busy/done handshake lets the control FSM launch one shift at a time.
module sll32_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
            $error("sll32_seq: STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP5 = 5'(STEP);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_d, done_d;
    logic [31:0] res_d;

    // Only the low five bits carry a shift amount.
    logic unused_a;
    assign unused_a = ^A[31:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            res     <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            res     <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        res_d   = res;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = B;
                    cnt_d   = A[4:0];
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd0) begin
                    res_d   = shreg_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q >= STEP5) begin
                    shreg_d = shreg_q << STEP;
                    cnt_d   = cnt_q - STEP5;
                end else begin
                    // Final partial step finishes the remainder in one go.
                    shreg_d = shreg_q << cnt_q;
                    cnt_d   = 5'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sll32_seq.sv
// Self-checking bench for sll32_seq: STEP=1 and STEP=4 instances, vector table,
// random operations against a plain-arithmetic model, and handshake corner cases.
module tb_sll32_seq;

    logic        clk, rst_n, start1, start4;
    logic [31:0] A, B;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;
    int          errors = 0, checks = 0, overlap = 0;

    sll32_seq #(.STEP(1)) u_s1 (.clk(clk), .rst_n(rst_n), .start(start1), .A(A), .B(B),
                                .busy(busy1), .done(done1), .res(res1));
    sll32_seq #(.STEP(4)) u_s4 (.clk(clk), .rst_n(rst_n), .start(start4), .A(A), .B(B),
                                .busy(busy4), .done(done4), .res(res4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if ((busy1 && done1) || (busy4 && done4)) overlap++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic bz(input int d); return d == 1 ? busy1 : busy4; endfunction
    function automatic logic dn(input int d); return d == 1 ? done1 : done4; endfunction
    function automatic logic [31:0] rr(input int d); return d == 1 ? res1 : res4; endfunction

    // Model: result is plain B << shamt; done follows ceil(shamt/STEP)+1 edges after start.
    function automatic int exp_lat(input int d, input logic [31:0] a);
        int sh = int'(a[4:0]);
        return (sh + d - 1) / d + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic run(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int el, input string nm);
        int lat;
        logic [31:0] got;
        @(negedge clk);
        A = a; B = b;
        if (d == 1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        chk({nm, " busy"}, 32'(bz(d)), 32'd1);
        lat = -1; got = 'x;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (dn(d)) begin lat = e; got = rr(d); break; end
        end
        chk({nm, " latency"}, 32'(lat), 32'(el));
        chk({nm, " res"}, got, er);
        chk({nm, " busy_at_done"}, 32'(bz(d)), 32'd0);
    endtask

    typedef struct {
        int          d;
        logic [31:0] a, b, res;
        int          lat;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   cnt, lat, d;
        logic [31:0] a, b, got;

        vecs[0] = '{1, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1};
        vecs[1] = '{1, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000, 32};
        vecs[2] = '{1, 32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 5};
        vecs[3] = '{1, 32'hFFFF_FFE4, 32'h0000_000F, 32'h0000_00F0, 5};
        vecs[4] = '{4, 32'h0000_000B, 32'h0000_0003, 32'h0000_1800, 4};
        vecs[5] = '{4, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[6] = '{4, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000, 9};

        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; A = '0; B = '0;
        #12;
        chk("reset busy", 32'({busy1, busy4}), 32'd0);
        chk("reset done", 32'({done1, done4}), 32'd0);
        chk("reset res1", res1, 32'd0);
        chk("reset res4", res4, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy1 || done1 || busy4 || done4 || res1 != 0 || res4 != 0) cnt++;
        end
        chk("idle outputs unchanged", 32'(cnt), 32'd0);

        foreach (vecs[i])
            run(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));

        // Asynchronous reset mid-cycle clears the held results at once.
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async reset res1", res1, 32'd0);
        chk("async reset res4", res4, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 4 : 1;
            a = $urandom; b = $urandom;
            run(d, a, b, b << a[4:0], exp_lat(d, a), $sformatf("rnd%0d", i));
        end

        // Operands change and a second start arrive while busy: both ignored.
        @(negedge clk); A = 32'h0000_0010; B = 32'h0000_0003; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        cnt = 0; lat = -1; got = 'x;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 3) begin A = 32'h0000_0001; B = 32'hFFFF_FFFF; start1 = 1'b1; end
            if (e == 4) start1 = 1'b0;
            if (done1) begin cnt++; if (lat < 0) begin lat = e; got = res1; end end
        end
        chk("busy start done count", 32'(cnt), 32'd1);
        chk("busy start latency", 32'(lat), 32'd17);
        chk("busy start res", got, 32'h0003_0000);

        // Start held in the done cycle is accepted with no idle gap.
        @(negedge clk); A = 32'd2; B = 32'd1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done1) begin lat = e; break; end
        end
        chk("b2b first latency", 32'(lat), 32'd3);
        chk("b2b first res", res1, 32'd4);
        A = 32'd3; B = 32'd5; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        chk("b2b accepted busy", 32'(busy1), 32'd1);
        chk("b2b accepted done cleared", 32'(done1), 32'd0);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done1) begin lat = e; break; end
        end
        chk("b2b second latency", 32'(lat), 32'd4);
        chk("b2b second res", res1, 32'h0000_0028);

        // Reset in the middle of a STEP=4 operation: no done, res cleared.
        run(4, 32'd4, 32'd1, 32'd16, 2, "pre-reset");
        @(negedge clk); A = 32'h0000_001F; B = 32'd1; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midop reset busy4", 32'(busy4), 32'd0);
        chk("midop reset res4", res4, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done4 || busy4) cnt++;
        end
        chk("midop reset no done", 32'(cnt), 32'd0);
        chk("midop reset res stays 0", res4, 32'd0);

        chk("busy/done never together", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
